mem_port_arbiter: RTL and testbench

Arbitrates the single memory-slave port between the instruction-fetch stage (read-only) and the memory stage (read/write). It holds one outstanding transaction at a time and registers the winning requester's address, data and size. It drives the shared S_R_*/S_W_* channels and routes each response back only to the requester that owns the transaction. Ties are broken round-robin so that neither the fetch stage nor the memory stage can starve.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates the single memory-slave port between fetch (read) and memory stage (read/write).
// Latency: request granted in IDLE, slave request issued next cycle; responses forwarded combinationally.
// Backpressure: one outstanding transaction; requesters hold VALID until their response/complete pulse.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   I_R_*               fetch read request / response
//   D_R_*               memory-stage read request / response
//   D_W_*               memory-stage write request, READY (idle), COMPLETE pulse
//   S_R_*, S_W_*        shared downstream read / write channels
//   busy                a transaction is outstanding
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_WIDTH-1:0] I_R_ADDR,
  input  logic                  I_R_ADDR_VALID,
  output logic [DATA_WIDTH-1:0] I_R_DATA,
  output logic                  I_R_DATA_VALID,

  input  logic [ADDR_WIDTH-1:0] D_R_ADDR,
  input  logic                  D_R_ADDR_VALID,
  output logic [DATA_WIDTH-1:0] D_R_DATA,
  output logic                  D_R_DATA_VALID,

  input  logic                  D_W_VALID,
  input  logic [ADDR_WIDTH-1:0] D_W_ADDR,
  input  logic [DATA_WIDTH-1:0] D_W_DATA,
  input  logic [1:0]            D_W_SIZE,
  output logic                  D_W_READY,
  output logic                  D_W_COMPLETE,

  output logic [ADDR_WIDTH-1:0] S_R_ADDR,
  output logic                  S_R_ADDR_VALID,
  input  logic [DATA_WIDTH-1:0] S_R_DATA,
  input  logic                  S_R_DATA_VALID,

  output logic                  S_W_VALID,
  output logic [ADDR_WIDTH-1:0] S_W_ADDR,
  output logic [DATA_WIDTH-1:0] S_W_DATA,
  output logic [1:0]            S_W_SIZE,
  input  logic                  S_W_READY,
  input  logic                  S_W_COMPLETE,

  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE_REQ,
    D_WRITE_WAIT
  } state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  state_t state, state_nxt;
  grant_t last_grant;

  logic [ADDR_WIDTH-1:0] s_r_addr_q;
  logic [ADDR_WIDTH-1:0] s_w_addr_q;
  logic [DATA_WIDTH-1:0] s_w_data_q;
  logic [1:0]            s_w_size_q;

  logic fetch_req;
  logic data_req;
  logic grant_data;
  logic grant_fetch;

  assign fetch_req = I_R_ADDR_VALID;
  assign data_req  = D_W_VALID | D_R_ADDR_VALID;

  // On a tie the side not granted last wins; reset value FETCH makes data win the first tie.
  assign grant_data  = (state == IDLE) && data_req && (!fetch_req || (last_grant == GRANT_FETCH));
  assign grant_fetch = (state == IDLE) && fetch_req && !grant_data;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_data) begin
          // A pending write goes ahead of a simultaneous data read.
          state_nxt = D_W_VALID ? D_WRITE_REQ : D_READ;
        end else if (grant_fetch) begin
          state_nxt = I_READ;
        end
      end
      I_READ, D_READ: begin
        if (S_R_DATA_VALID) state_nxt = IDLE;
      end
      D_WRITE_REQ: begin
        if (S_W_READY) state_nxt = D_WRITE_WAIT;
      end
      D_WRITE_WAIT: begin
        if (S_W_COMPLETE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GRANT_FETCH;
      s_r_addr_q <= '0;
      s_w_addr_q <= '0;
      s_w_data_q <= '0;
      s_w_size_q <= '0;
    end else begin
      if (grant_data) begin
        last_grant <= GRANT_DATA;
        if (D_W_VALID) begin
          s_w_addr_q <= D_W_ADDR;
          s_w_data_q <= D_W_DATA;
          s_w_size_q <= D_W_SIZE;
        end else begin
          s_r_addr_q <= D_R_ADDR;
        end
      end else if (grant_fetch) begin
        last_grant <= GRANT_FETCH;
        s_r_addr_q <= I_R_ADDR;
      end
    end
  end

  // Read data is shared; only the valid is steered to the owning requester.
  assign I_R_DATA       = S_R_DATA;
  assign D_R_DATA       = S_R_DATA;
  assign I_R_DATA_VALID = (state == I_READ) && S_R_DATA_VALID;
  assign D_R_DATA_VALID = (state == D_READ) && S_R_DATA_VALID;

  assign S_R_ADDR       = s_r_addr_q;
  assign S_R_ADDR_VALID = (state == I_READ) || (state == D_READ);

  assign S_W_VALID      = (state == D_WRITE_REQ);
  assign S_W_ADDR       = s_w_addr_q;
  assign S_W_DATA       = s_w_data_q;
  assign S_W_SIZE       = s_w_size_q;

  assign D_W_COMPLETE   = (state == D_WRITE_WAIT) && S_W_COMPLETE;
  // Purely state-based so requesters may derive VALID from READY without a loop.
  assign D_W_READY      = (state == IDLE);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed self-checking bench for mem_port_arbiter.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked 1 unit later.
// Backpressure: slave READY/COMPLETE/DATA_VALID timing scripted per test step.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [63:0] I_R_ADDR = '0;
  logic        I_R_ADDR_VALID = 1'b0;
  logic [63:0] I_R_DATA;
  logic        I_R_DATA_VALID;
  logic [63:0] D_R_ADDR = '0;
  logic        D_R_ADDR_VALID = 1'b0;
  logic [63:0] D_R_DATA;
  logic        D_R_DATA_VALID;
  logic        D_W_VALID = 1'b0;
  logic [63:0] D_W_ADDR = '0;
  logic [63:0] D_W_DATA = '0;
  logic [1:0]  D_W_SIZE = '0;
  logic        D_W_READY;
  logic        D_W_COMPLETE;
  logic [63:0] S_R_ADDR;
  logic        S_R_ADDR_VALID;
  logic [63:0] S_R_DATA = '0;
  logic        S_R_DATA_VALID = 1'b0;
  logic        S_W_VALID;
  logic [63:0] S_W_ADDR;
  logic [63:0] S_W_DATA;
  logic [1:0]  S_W_SIZE;
  logic        S_W_READY = 1'b0;
  logic        S_W_COMPLETE = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .I_R_ADDR       (I_R_ADDR),
    .I_R_ADDR_VALID (I_R_ADDR_VALID),
    .I_R_DATA       (I_R_DATA),
    .I_R_DATA_VALID (I_R_DATA_VALID),
    .D_R_ADDR       (D_R_ADDR),
    .D_R_ADDR_VALID (D_R_ADDR_VALID),
    .D_R_DATA       (D_R_DATA),
    .D_R_DATA_VALID (D_R_DATA_VALID),
    .D_W_VALID      (D_W_VALID),
    .D_W_ADDR       (D_W_ADDR),
    .D_W_DATA       (D_W_DATA),
    .D_W_SIZE       (D_W_SIZE),
    .D_W_READY      (D_W_READY),
    .D_W_COMPLETE   (D_W_COMPLETE),
    .S_R_ADDR       (S_R_ADDR),
    .S_R_ADDR_VALID (S_R_ADDR_VALID),
    .S_R_DATA       (S_R_DATA),
    .S_R_DATA_VALID (S_R_DATA_VALID),
    .S_W_VALID      (S_W_VALID),
    .S_W_ADDR       (S_W_ADDR),
    .S_W_DATA       (S_W_DATA),
    .S_W_SIZE       (S_W_SIZE),
    .S_W_READY      (S_W_READY),
    .S_W_COMPLETE   (S_W_COMPLETE),
    .busy           (busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_i;
    int cnt_i;
    int cnt_d;

    // ---------------- reset state ----------------
    tick(); tick();
    chk1("rst_busy",       busy,           1'b0);
    chk1("rst_dw_ready",   D_W_READY,      1'b1);
    chk1("rst_sr_valid",   S_R_ADDR_VALID, 1'b0);
    chk1("rst_sw_valid",   S_W_VALID,      1'b0);
    chk64("rst_sr_addr",   S_R_ADDR,       64'h0);
    chk64("rst_sw_addr",   S_W_ADDR,       64'h0);
    chk64("rst_sw_data",   S_W_DATA,       64'h0);
    chk64("rst_sw_size",   64'(S_W_SIZE),  64'h0);
    chk1("rst_i_valid",    I_R_DATA_VALID, 1'b0);
    chk1("rst_d_valid",    D_R_DATA_VALID, 1'b0);
    chk1("rst_dw_cmpl",    D_W_COMPLETE,   1'b0);
    reset = 1'b1;

    // ---------------- fetch read 0x1000, response after 3 cycles ----------------
    tick();
    I_R_ADDR = 64'h1000; I_R_ADDR_VALID = 1'b1;
    settle();
    chk1("f_grant_busy", busy, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk1("f_sr_valid",  S_R_ADDR_VALID, 1'b1);
      chk64("f_sr_addr",  S_R_ADDR,       64'h1000);
      chk1("f_i_valid0",  I_R_DATA_VALID, 1'b0);
      chk1("f_dw_ready0", D_W_READY,      1'b0);
    end
    tick();
    S_R_DATA = 64'hDEADBEEF; S_R_DATA_VALID = 1'b1;
    settle();
    chk1("f_sr_valid3", S_R_ADDR_VALID, 1'b1);
    chk1("f_i_valid",   I_R_DATA_VALID, 1'b1);
    chk64("f_i_data",   I_R_DATA,       64'hDEADBEEF);
    chk1("f_d_valid",   D_R_DATA_VALID, 1'b0);
    tick();
    S_R_DATA_VALID = 1'b0; I_R_ADDR_VALID = 1'b0;
    settle();
    chk1("f_idle_busy",   busy,           1'b0);
    chk1("f_idle_srv",    S_R_ADDR_VALID, 1'b0);
    chk1("f_idle_ivalid", I_R_DATA_VALID, 1'b0);

    // ---------------- tie after reset: data, fetch, data, fetch ----------------
    reset = 1'b0;
    tick();
    reset = 1'b1;
    I_R_ADDR = 64'h40; I_R_ADDR_VALID = 1'b1;
    D_R_ADDR = 64'h80; D_R_ADDR_VALID = 1'b1;
    tick();
    S_R_DATA = 64'hAA; S_R_DATA_VALID = 1'b1;
    settle();
    chk64("t1_addr",   S_R_ADDR,       64'h80);
    chk1("t1_dvalid",  D_R_DATA_VALID, 1'b1);
    chk1("t1_ivalid",  I_R_DATA_VALID, 1'b0);
    chk64("t1_ddata",  D_R_DATA,       64'hAA);
    tick();
    S_R_DATA_VALID = 1'b0; D_R_ADDR_VALID = 1'b0;
    settle();
    chk1("t2_idle", busy, 1'b0);
    tick();
    // Data request raised while a fetch is in flight must wait for IDLE.
    D_R_ADDR = 64'h88; D_R_ADDR_VALID = 1'b1;
    S_R_DATA = 64'hBB; S_R_DATA_VALID = 1'b1;
    settle();
    chk64("t2_addr",  S_R_ADDR,       64'h40);
    chk1("t2_ivalid", I_R_DATA_VALID, 1'b1);
    chk1("t2_dvalid", D_R_DATA_VALID, 1'b0);
    tick();
    S_R_DATA_VALID = 1'b0;
    I_R_ADDR = 64'h44;
    tick();
    chk64("t3_addr",  S_R_ADDR,       64'h88);
    chk1("t3_srv",    S_R_ADDR_VALID, 1'b1);
    S_R_DATA_VALID = 1'b1;
    settle();
    chk1("t3_dvalid", D_R_DATA_VALID, 1'b1);
    tick();
    S_R_DATA_VALID = 1'b0; D_R_ADDR_VALID = 1'b0;
    tick();
    chk64("t4_addr", S_R_ADDR, 64'h44);
    S_R_DATA_VALID = 1'b1;
    settle();
    chk1("t4_ivalid", I_R_DATA_VALID, 1'b1);
    tick();
    S_R_DATA_VALID = 1'b0; I_R_ADDR_VALID = 1'b0;

    // ---------------- write with delayed READY/COMPLETE; read waits behind it ----------------
    D_W_ADDR = 64'h200; D_W_DATA = 64'h1122334455667788; D_W_SIZE = 2'd3; D_W_VALID = 1'b1;
    D_R_ADDR = 64'h300; D_R_ADDR_VALID = 1'b1;
    settle();
    chk1("w_ready_idle", D_W_READY, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk1("w_swvalid",  S_W_VALID,      1'b1);
      chk1("w_srv0",     S_R_ADDR_VALID, 1'b0);
      chk1("w_ready0",   D_W_READY,      1'b0);
    end
    chk64("w_addr",  S_W_ADDR,       64'h200);
    chk64("w_data",  S_W_DATA,       64'h1122334455667788);
    chk64("w_size",  64'(S_W_SIZE),  64'h3);
    tick();
    S_W_READY = 1'b1;
    settle();
    chk1("w_swvalid_rdy", S_W_VALID, 1'b1);
    tick();
    S_W_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk1("w_wait_swvalid", S_W_VALID,    1'b0);
      chk1("w_wait_cmpl",    D_W_COMPLETE, 1'b0);
      tick();
    end
    S_W_COMPLETE = 1'b1;
    settle();
    chk1("w_cmpl", D_W_COMPLETE, 1'b1);
    tick();
    S_W_COMPLETE = 1'b0; D_W_VALID = 1'b0;
    settle();
    chk1("w_cmpl_pulse", D_W_COMPLETE, 1'b0);
    chk1("w_ready_back", D_W_READY,    1'b1);
    tick();
    chk64("w_rd_addr", S_R_ADDR,       64'h300);
    chk1("w_rd_srv",   S_R_ADDR_VALID, 1'b1);
    S_R_DATA_VALID = 1'b1;
    settle();
    chk1("w_rd_dvalid", D_R_DATA_VALID, 1'b1);
    tick();
    S_R_DATA_VALID = 1'b0; D_R_ADDR_VALID = 1'b0;

    // ---------------- continuous contention over 100 cycles ----------------
    I_R_ADDR = 64'h500; I_R_ADDR_VALID = 1'b1;
    D_R_ADDR = 64'h600; D_R_ADDR_VALID = 1'b1;
    first_i = -1; cnt_i = 0; cnt_d = 0;
    for (int c = 0; c < 100; c++) begin
      S_R_DATA_VALID = 1'b0;
      settle();
      if (S_R_ADDR_VALID) begin
        S_R_DATA = 64'(c);
        S_R_DATA_VALID = 1'b1;
      end
      settle();
      if (I_R_DATA_VALID) begin
        cnt_i++;
        if (first_i < 0) first_i = c;
      end
      if (D_R_DATA_VALID) cnt_d++;
      tick();
    end
    S_R_DATA_VALID = 1'b0; I_R_ADDR_VALID = 1'b0; D_R_ADDR_VALID = 1'b0;
    chk1("s_first_fetch", (first_i >= 0) && (first_i <= 3), 1'b1);
    chk64("s_cnt_fetch", 64'(cnt_i), 64'd25);
    chk64("s_cnt_data",  64'(cnt_d), 64'd25);
    settle();
    chk1("s_idle", busy, 1'b0);

    // ---------------- spurious slave responses while IDLE ----------------
    tick();
    S_R_DATA_VALID = 1'b1; S_W_COMPLETE = 1'b1;
    settle();
    chk1("sp_ivalid", I_R_DATA_VALID, 1'b0);
    chk1("sp_dvalid", D_R_DATA_VALID, 1'b0);
    chk1("sp_cmpl",   D_W_COMPLETE,   1'b0);
    tick();
    S_R_DATA_VALID = 1'b0; S_W_COMPLETE = 1'b0;
    settle();
    chk1("sp_busy",  busy,      1'b0);
    chk1("sp_ready", D_W_READY, 1'b1);

    // ---------------- reset during I_READ ----------------
    tick();
    I_R_ADDR = 64'h700; I_R_ADDR_VALID = 1'b1;
    tick();
    chk1("r_srv_before", S_R_ADDR_VALID, 1'b1);
    reset = 1'b0;
    settle();
    chk1("r_srv_after", S_R_ADDR_VALID, 1'b0);
    chk1("r_busy",      busy,           1'b0);
    chk64("r_sr_addr",  S_R_ADDR,       64'h0);
    I_R_ADDR_VALID = 1'b0;
    settle();
    reset = 1'b1;
    tick();
    S_R_DATA_VALID = 1'b1;
    settle();
    chk1("r_late_ivalid", I_R_DATA_VALID, 1'b0);
    tick();
    S_R_DATA_VALID = 1'b0;
    settle();
    chk1("r_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
